// File: rtl/gpio_in_cond.sv
// Pad input conditioning: 2-FF synchronizer, tick-based per-pin debouncer, RISE/FALL event pulses.
// Optional sticky event flags with write-1 clear are enabled by defining GPIO_IN_STICKY_EN.
module gpio_in_cond #(
  parameter int unsigned SZ   = 8,
  parameter int unsigned PW   = 16,
  parameter int unsigned DB_N = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [SZ-1:0] PAD_IN,
  input  logic [SZ-1:0] DB_EN,
  input  logic [PW-1:0] DB_PERIOD,
  output logic [SZ-1:0] GPIO_DIN,
  output logic [SZ-1:0] RISE,
`ifdef GPIO_IN_STICKY_EN
  output logic [SZ-1:0] FALL,
  input  logic [SZ-1:0] EVT_CLR,
  output logic [SZ-1:0] EVT
`else
  output logic [SZ-1:0] FALL
`endif
);

  localparam int unsigned CW = (DB_N > 2) ? $clog2(DB_N) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_N - 1);

  logic [SZ-1:0]         s1;
  logic [SZ-1:0]         s2;
  logic [PW-1:0]         pcnt;
  logic                  tick;
  logic [SZ-1:0][CW-1:0] cnt;
  logic [SZ-1:0][CW-1:0] cnt_nx;
  logic [SZ-1:0]         din_nx;

  // Two-stage synchronizer for the asynchronous pads
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= PAD_IN;
      s2 <= s1;
    end
  end

  // Shared prescaler; >= compare means a lowered period never wraps through 2^PW
  assign tick = (pcnt >= DB_PERIOD);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Per-pin debounce: accept a new level on the DB_N-th consecutive disagreeing tick
  always_comb begin
    din_nx = GPIO_DIN;
    cnt_nx = cnt;
    for (int i = 0; i < int'(SZ); i++) begin
      if (!DB_EN[i]) begin
        din_nx[i] = s2[i];
        cnt_nx[i] = '0;
      end else if (tick) begin
        if (s2[i] == GPIO_DIN[i]) begin
          cnt_nx[i] = '0;
        end else if (cnt[i] >= CMAX) begin
          din_nx[i] = s2[i];
          cnt_nx[i] = '0;
        end else begin
          cnt_nx[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt      <= '0;
      GPIO_DIN <= '0;
      RISE     <= '0;
      FALL     <= '0;
    end else begin
      cnt      <= cnt_nx;
      GPIO_DIN <= din_nx;
      RISE     <= din_nx & ~GPIO_DIN;
      FALL     <= ~din_nx & GPIO_DIN;
    end
  end

`ifdef GPIO_IN_STICKY_EN
  // Sticky flags; a new event wins over a same-cycle clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      EVT <= '0;
    end else begin
      EVT <= (EVT & ~EVT_CLR) | RISE | FALL;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond: reset, bypass vector table via scoreboard queue,
// debounce latency, glitch rejection, prescaler period change, mid-count reset, sticky events.
module tb_gpio_in_cond;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] din;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  localparam int NV = 12;

  logic        HCLK;
  logic        HRESETn;
  logic [7:0]  PAD_IN;
  logic [7:0]  DB_EN;
  logic [15:0] DB_PERIOD;
  logic [7:0]  GPIO_DIN;
  logic [7:0]  RISE;
  logic [7:0]  FALL;
`ifdef GPIO_IN_STICKY_EN
  logic [7:0]  EVT_CLR;
  logic [7:0]  EVT;
`endif

  int checks = 0;
  int errors = 0;

  vec_t vecs [NV];
  vec_t exp_q [$];

  gpio_in_cond #(.SZ(8), .PW(16), .DB_N(4)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PAD_IN    (PAD_IN),
    .DB_EN     (DB_EN),
    .DB_PERIOD (DB_PERIOD),
    .GPIO_DIN  (GPIO_DIN),
    .RISE      (RISE),
`ifdef GPIO_IN_STICKY_EN
    .FALL      (FALL),
    .EVT_CLR   (EVT_CLR),
    .EVT       (EVT)
`else
    .FALL      (FALL)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_reset;
    HRESETn = 1'b0;
    #2;
    chk("rst_pulse_din", 32'(GPIO_DIN), 32'h0);
    chk("rst_pulse_evts", 32'(RISE | FALL), 32'h0);
    HRESETn = 1'b1;
  endtask

  initial begin
    vec_t e;
    int   idx;
    int   first;
    int   rises;
    int   falls;
    int   highs;
    int   found;

    vecs[0]  = '{8'h01, 8'h01, 8'h01, 8'h00};
    vecs[1]  = '{8'h01, 8'h01, 8'h00, 8'h00};
    vecs[2]  = '{8'hA5, 8'hA5, 8'hA4, 8'h00};
    vecs[3]  = '{8'h5A, 8'h5A, 8'h5A, 8'hA5};
    vecs[4]  = '{8'hFF, 8'hFF, 8'hA5, 8'h00};
    vecs[5]  = '{8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{8'h3C, 8'h3C, 8'h3C, 8'h00};
    vecs[8]  = '{8'h3C, 8'h3C, 8'h00, 8'h00};
    vecs[9]  = '{8'hC3, 8'hC3, 8'hC3, 8'h3C};
    vecs[10] = '{8'h3C, 8'h3C, 8'h3C, 8'hC3};
    vecs[11] = '{8'h3C, 8'h3C, 8'h00, 8'h00};

    HRESETn   = 1'b0;
    PAD_IN    = 8'hFF;
    DB_EN     = 8'h00;
    DB_PERIOD = 16'd9;
`ifdef GPIO_IN_STICKY_EN
    EVT_CLR   = 8'h00;
`endif

    // Reset state and release latency
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_din", 32'(GPIO_DIN), 32'h0);
    chk("rst_rise", 32'(RISE), 32'h0);
    chk("rst_fall", 32'(FALL), 32'h0);
`ifdef GPIO_IN_STICKY_EN
    chk("rst_evt", 32'(EVT), 32'h0);
`endif
    HRESETn = 1'b1;
    step; chk("rel_e1_din", 32'(GPIO_DIN), 32'h0);
    step; chk("rel_e2_din", 32'(GPIO_DIN), 32'h0);
    step; chk("rel_e3_din", 32'(GPIO_DIN), 32'hFF);
          chk("rel_e3_rise", 32'(RISE), 32'hFF);
    step; chk("rel_e4_rise", 32'(RISE), 32'h0);
          chk("rel_e4_din", 32'(GPIO_DIN), 32'hFF);
    PAD_IN = 8'h00;
    repeat (4) step;
    chk("settle_din", 32'(GPIO_DIN), 32'h0);

    // Bypass vector table through a 3-deep scoreboard
    idx = 0;
    for (int i = 0; i < NV; i++) begin
      step;
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        chk($sformatf("vec%0d_din", idx), 32'(GPIO_DIN), 32'(e.din));
        chk($sformatf("vec%0d_rise", idx), 32'(RISE), 32'(e.rise));
        chk($sformatf("vec%0d_fall", idx), 32'(FALL), 32'(e.fall));
        idx++;
      end
      PAD_IN = vecs[i].pad;
      exp_q.push_back(vecs[i]);
    end
    while (exp_q.size() > 0) begin
      step;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_din", idx), 32'(GPIO_DIN), 32'(e.din));
      chk($sformatf("vec%0d_rise", idx), 32'(RISE), 32'(e.rise));
      chk($sformatf("vec%0d_fall", idx), 32'(FALL), 32'(e.fall));
      idx++;
    end

`ifdef GPIO_IN_STICKY_EN
    // Sticky flags: set, hold, clear, event beats clear
    EVT_CLR = 8'hFF;
    step;
    chk("evt_clr_all", 32'(EVT), 32'h0);
    EVT_CLR = 8'h00;
    PAD_IN = 8'h1C;
    found = 0;
    for (int n = 0; n < 10; n++) begin
      step;
      if (FALL[5]) begin found = 1; break; end
    end
    chk("fall5_seen", 32'(found), 32'h1);
    step; chk("evt5_set", 32'(EVT[5]), 32'h1);
    repeat (3) step;
    chk("evt5_hold", 32'(EVT), 32'h20);
    PAD_IN = 8'h3C;
    found = 0;
    for (int n = 0; n < 10; n++) begin
      step;
      if (RISE[5]) begin found = 1; break; end
    end
    chk("rise5_seen", 32'(found), 32'h1);
    EVT_CLR = 8'h20;
    step; chk("evt5_event_beats_clr", 32'(EVT[5]), 32'h1);
    step; chk("evt5_clr", 32'(EVT[5]), 32'h0);
    EVT_CLR = 8'h00;
    step; chk("evt5_stays_clr", 32'(EVT[5]), 32'h0);
`endif

    PAD_IN = 8'h00;
    DB_EN  = 8'h00;
    repeat (5) step;

    // Debounced rise and fall on pin 3 (period 10 cycles, 4 ticks)
    DB_PERIOD = 16'd9;
    DB_EN     = 8'h08;
    step;
    PAD_IN = 8'h08;
    first = 0; rises = 0; falls = 0;
    for (int n = 1; n <= 50; n++) begin
      step;
      if (GPIO_DIN[3] && first == 0) first = n;
      rises += int'(RISE[3]);
      falls += int'(FALL[3]);
    end
    chk_rng("db_rise_latency", first, 32, 42);
    chk("db_rise_count", 32'(rises), 32'd1);
    chk("db_fall_count_during_rise", 32'(falls), 32'd0);
    chk("db_din_hold", 32'(GPIO_DIN), 32'h08);
    PAD_IN = 8'h00;
    first = 0; falls = 0;
    for (int n = 1; n <= 60; n++) begin
      step;
      if (!GPIO_DIN[3] && first == 0) first = n;
      falls += int'(FALL[3]);
    end
    chk_rng("db_fall_latency", first, 32, 42);
    chk("db_fall_count", 32'(falls), 32'd1);

    // Glitch of 15 cycles must be rejected
    PAD_IN = 8'h08;
    highs = 0; rises = 0; falls = 0;
    for (int n = 1; n <= 60; n++) begin
      step;
      if (n == 15) PAD_IN = 8'h00;
      highs += int'(GPIO_DIN[3]);
      rises += int'(RISE[3]);
      falls += int'(FALL[3]);
    end
    chk("glitch_din_high", 32'(highs), 32'd0);
    chk("glitch_events", 32'(rises + falls), 32'd0);

    // Lowering the period below the running count ticks on the next cycle
    DB_PERIOD = 16'd1000;
    PAD_IN    = 8'h08;
    pulse_reset;
    repeat (500) step;
    chk("per_no_tick_yet", 32'(GPIO_DIN[3]), 32'h0);
    DB_PERIOD = 16'd2;
    first = 0;
    for (int n = 1; n <= 30; n++) begin
      step;
      if (GPIO_DIN[3] && first == 0) first = n;
    end
    chk("per_change_latency", 32'(first), 32'd10);

    // Reset mid-count restarts the debounce from scratch
    DB_PERIOD = 16'd9;
    PAD_IN    = 8'h00;
    repeat (60) step;
    chk("rmc_low", 32'(GPIO_DIN[3]), 32'h0);
    PAD_IN = 8'h08;
    repeat (25) step;
    chk("rmc_pre_din", 32'(GPIO_DIN[3]), 32'h0);
    pulse_reset;
    first = 0;
    for (int n = 1; n <= 60; n++) begin
      step;
      if (GPIO_DIN[3] && first == 0) first = n;
    end
    chk("rmc_restart_latency", 32'(first), 32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
